// File: rtl/auth_msg_tx.sv
// Authentication message transmitter: captures one request, streams it as a USB
// control-write (setup + data stage), hands back the Ack, then times the response.
module auth_msg_tx #(
  parameter int unsigned HDR_BYTES = 4,
  parameter int unsigned PAY_BYTES = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Ack_in,
  input  logic [7:0]             bmRequestType,
  input  logic [7:0]             bRequest,
  input  logic [15:0]            wLength,
  input  logic [8*HDR_BYTES-1:0] header,
  input  logic [8*PAY_BYTES-1:0] payload,
  input  logic [31:0]            current_timeout,
  output logic                   Ack_out,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   rsp_valid,
  output logic                   rsp_ok,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int unsigned MAX_BYTES = HDR_BYTES + PAY_BYTES;
  localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1);
  localparam int unsigned IDX_W     = (LEN_W > 3) ? LEN_W : 3;
  localparam int unsigned MSG_W     = 8 * MAX_BYTES;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    DATA     = 3'd2,
    HANDOFF  = 3'd3,
    WAIT_RSP = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [31:0]            timer_q, timer_d;
  logic                   ack_prev_q, ack_prev_d;
  logic [7:0]             bm_req_q, bm_req_d;
  logic [7:0]             b_req_q, b_req_d;
  logic [15:0]            w_length_q, w_length_d;
  logic [8*HDR_BYTES-1:0] header_q, header_d;
  logic [8*PAY_BYTES-1:0] payload_q, payload_d;
  logic [31:0]            timeout_q, timeout_d;
  logic                   ack_out_q, ack_out_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   rsp_ok_q, rsp_ok_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   busy_q, busy_d;
  logic [MSG_W-1:0]       msg_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      timer_q       <= '0;
      ack_prev_q    <= 1'b0;
      bm_req_q      <= '0;
      b_req_q       <= '0;
      w_length_q    <= '0;
      header_q      <= '0;
      payload_q     <= '0;
      timeout_q     <= '0;
      ack_out_q     <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rsp_ok_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      timer_q       <= timer_d;
      ack_prev_q    <= ack_prev_d;
      bm_req_q      <= bm_req_d;
      b_req_q       <= b_req_d;
      w_length_q    <= w_length_d;
      header_q      <= header_d;
      payload_q     <= payload_d;
      timeout_q     <= timeout_d;
      ack_out_q     <= ack_out_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      rsp_ok_q      <= rsp_ok_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next state, then outputs derived from the next state so they register with it.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    timer_d       = timer_q;
    ack_prev_d    = Ack_in;
    bm_req_d      = bm_req_q;
    b_req_d       = b_req_q;
    w_length_d    = w_length_q;
    header_d      = header_q;
    payload_d     = payload_q;
    timeout_d     = timeout_q;
    rsp_ok_d      = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Ack_in && !ack_prev_q) begin
          bm_req_d   = bmRequestType;
          b_req_d    = bRequest;
          w_length_d = wLength;
          header_d   = header;
          payload_d  = payload;
          timeout_d  = current_timeout;
          len_d      = (wLength > 16'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : LEN_W'(wLength);
          idx_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tx_ready) begin
          if (idx_q == IDX_W'(7)) begin
            idx_d   = '0;
            state_d = (len_q != '0) ? DATA : HANDOFF;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DATA: begin
        if (tx_ready) begin
          if (idx_q == IDX_W'(len_q) - IDX_W'(1)) begin
            idx_d   = '0;
            state_d = HANDOFF;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HANDOFF: begin
        if (!Ack_in) begin
          timer_d = timeout_q;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the same cycle the timer hits zero still counts as on time.
        if (rsp_valid) begin
          rsp_ok_d = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    msg_d      = {payload_d, header_d};
    tx_data_d  = '0;
    tx_valid_d = (state_d == SETUP) || (state_d == DATA);
    if (state_d == SETUP) begin
      unique case (idx_d[2:0])
        3'd0:    tx_data_d = bm_req_d;
        3'd1:    tx_data_d = b_req_d;
        3'd2:    tx_data_d = header_d[15:8];
        3'd6:    tx_data_d = w_length_d[7:0];
        3'd7:    tx_data_d = w_length_d[15:8];
        default: tx_data_d = 8'h00;
      endcase
    end else if (state_d == DATA) begin
      tx_data_d = 8'(msg_d >> {idx_d, 3'b000});
    end
    ack_out_d = (state_d == HANDOFF);
    busy_d    = (state_d != IDLE);
  end

  assign Ack_out     = ack_out_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign rsp_ok      = rsp_ok_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_auth_msg_tx.sv
// Directed bench for auth_msg_tx: byte streams, backpressure, clamp, timeout and reset.
module tb_auth_msg_tx;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned PAY_BYTES = 12;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   Ack_in;
  logic [7:0]             bmRequestType;
  logic [7:0]             bRequest;
  logic [15:0]            wLength;
  logic [8*HDR_BYTES-1:0] header;
  logic [8*PAY_BYTES-1:0] payload;
  logic [31:0]            current_timeout;
  logic                   Ack_out;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   rsp_valid;
  logic                   rsp_ok;
  logic                   timeout_err;
  logic                   busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp[$];
  int  ncyc;
  bit  first_ok;

  auth_msg_tx #(.HDR_BYTES(HDR_BYTES), .PAY_BYTES(PAY_BYTES)) dut (
    .clk(clk), .reset(reset), .Ack_in(Ack_in), .bmRequestType(bmRequestType),
    .bRequest(bRequest), .wLength(wLength), .header(header), .payload(payload),
    .current_timeout(current_timeout), .Ack_out(Ack_out), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [7:0] bm, input logic [7:0] br, input logic [15:0] wl,
                         input logic [31:0] hdr, input logic [95:0] pay, input logic [31:0] tmo);
    bmRequestType = bm; bRequest = br; wLength = wl;
    header = hdr; payload = pay; current_timeout = tmo;
  endtask

  // Reference stream from the bench's own request fields.
  task automatic build_exp();
    logic [127:0] msg;
    int n;
    msg = {payload, header};
    n = (wLength > 16'd16) ? 16 : int'(wLength);
    exp.delete();
    exp.push_back(bmRequestType); exp.push_back(bRequest); exp.push_back(header[15:8]);
    exp.push_back(8'h00); exp.push_back(8'h00); exp.push_back(8'h00);
    exp.push_back(wLength[7:0]); exp.push_back(wLength[15:8]);
    for (int i = 0; i < n; i++) exp.push_back(8'(msg >> (8 * i)));
  endtask

  task automatic start_xfer();
    @(negedge clk); Ack_in = 1'b1;
    @(posedge clk);
  endtask

  // mode 0: ready always; mode 1: ready pattern 1,0,0 repeating.
  task automatic collect(input int nbytes, input int mode, input bit hold);
    bit stall_prev;
    logic [7:0] prev;
    got.delete(); ncyc = 0; stall_prev = 0; prev = '0; first_ok = 0;
    while (got.size() < nbytes && ncyc < 300) begin
      @(negedge clk);
      Ack_in = hold;
      ncyc++;
      tx_ready = (mode == 0) ? 1'b1 : (ncyc % 3 == 1);
      if (ncyc == 1) first_ok = tx_valid;
      if (tx_valid) begin
        if (stall_prev) begin
          checks++;
          if (tx_data !== prev) begin
            errors++;
            $display("FAIL stall_stable: tx_data=%h required %h", tx_data, prev);
          end
        end
        if (tx_ready) got.push_back(tx_data);
        stall_prev = !tx_ready;
        prev = tx_data;
      end else stall_prev = 0;
    end
    tx_ready = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Ack_in = 0; tx_ready = 1; rsp_valid = 0;
    set_req(8'h00, 8'h00, 16'h0, 32'h0, 96'h0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if ({Ack_out, tx_valid, tx_data, rsp_ok, timeout_err, busy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {Ack_out, tx_valid, tx_data, rsp_ok, timeout_err, busy});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    set_req(8'h41, 8'h0C, 16'd4, 32'h0011_0110, 96'h0, 32'd2);
    build_exp();
    start_xfer();
    collect(12, 0, 0);
    checks++;
    if (!first_ok) begin errors++; $display("FAIL basic_first_byte: tx_valid=0 required 1"); end
    checks++;
    if (got.size() != 12) begin errors++; $display("FAIL basic_count: got %0d required 12", got.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (ncyc != 12) begin errors++; $display("FAIL basic_cycles: got %0d required 12", ncyc); end
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ack: Ack_out=%b tx_valid=%b required 1 0", Ack_out, tx_valid);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_idle: busy stuck required 0"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    set_req(8'h41, 8'h0C, 16'd16, 32'h0302_0100, 96'h0F0E0D0C_0B0A0908_07060504, 32'd2);
    build_exp();
    start_xfer();
    collect(24, 1, 0);
    checks++;
    if (got.size() != 24) begin errors++; $display("FAIL bp_count: got %0d required 24", got.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got[i], exp[i]); end
    end
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL bp_ack: Ack_out=%b tx_valid=%b required 1 0", Ack_out, tx_valid);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_idle: busy stuck required 0"); end
  endtask

  task automatic test_clamp();
    bit ok;
    set_req(8'hC1, 8'h05, 16'h0100, 32'h0302_0100, 96'h0F0E0D0C_0B0A0908_07060504, 32'd2);
    build_exp();
    start_xfer();
    collect(24, 0, 0);
    checks++;
    if (got.size() != 24) begin errors++; $display("FAIL clamp_count: got %0d required 24", got.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL clamp_byte%0d: got %h required %h", i, got[i], exp[i]); end
    end
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL clamp_end: Ack_out=%b tx_valid=%b required 1 0", Ack_out, tx_valid);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clamp_idle: busy stuck required 0"); end
  endtask

  task automatic test_zero_len();
    bit ok;
    set_req(8'h41, 8'h0C, 16'd0, 32'hAABB_CCDD, 96'h0, 32'd2);
    build_exp();
    start_xfer();
    collect(8, 0, 0);
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL zero_byte%0d: got %h required %h", i, got[i], exp[i]); end
    end
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL zero_handoff: Ack_out=%b tx_valid=%b required 1 0", Ack_out, tx_valid);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_idle: busy stuck required 0"); end
  endtask

  task automatic test_timeout();
    bit early;
    set_req(8'h41, 8'h0C, 16'd0, 32'h0, 96'h0, 32'd5);
    start_xfer();
    collect(8, 0, 0);
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1) begin errors++; $display("FAIL to_handoff: Ack_out=%b required 1", Ack_out); end
    early = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (timeout_err || !busy || rsp_ok) early = 1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL to_early: early termination got 1 required 0"); end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || rsp_ok !== 1'b0) begin
      errors++; $display("FAIL to_pulse: timeout_err=%b busy=%b rsp_ok=%b required 1 0 0", timeout_err, busy, rsp_ok);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_width: timeout_err=%b required 0", timeout_err); end
  endtask

  task automatic test_rsp_coincident();
    set_req(8'h41, 8'h0C, 16'd0, 32'h0, 96'h0, 32'd3);
    start_xfer();
    collect(8, 0, 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    @(negedge clk); rsp_valid = 1'b1;
    @(negedge clk); rsp_valid = 1'b0;
    checks++;
    if (rsp_ok !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL coinc: rsp_ok=%b timeout_err=%b busy=%b required 1 0 0", rsp_ok, timeout_err, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_ok !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL coinc_after: rsp_ok=%b timeout_err=%b required 0 0", rsp_ok, timeout_err);
    end
  endtask

  task automatic test_ack_held();
    bit ok;
    set_req(8'h41, 8'h0C, 16'd4, 32'h0011_0110, 96'h0, 32'd2);
    start_xfer();
    collect(12, 0, 1);
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1) begin errors++; $display("FAIL held_ack: Ack_out=%b required 1", Ack_out); end
    repeat (4) @(negedge clk);
    checks++;
    if (Ack_out !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL held_hold: Ack_out=%b busy=%b required 1 1", Ack_out, busy);
    end
    Ack_in = 1'b0;
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b0) begin errors++; $display("FAIL held_release: Ack_out=%b required 0", Ack_out); end
    Ack_in = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL held_idle: busy stuck required 0"); end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL held_retrigger: busy=%b tx_valid=%b required 0 0", busy, tx_valid);
    end
    Ack_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_req(8'h41, 8'h0C, 16'd16, 32'h0302_0100, 96'h0F0E0D0C_0B0A0908_07060504, 32'd2);
    build_exp();
    start_xfer();
    collect(10, 0, 0);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
      errors++; $display("FAIL rst_byte10: tx_valid=%b tx_data=%h required 1 02", tx_valid, tx_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({Ack_out, tx_valid, tx_data, rsp_ok, timeout_err, busy} !== 13'h0) begin
      errors++; $display("FAIL rst_async: got %b required 0", {Ack_out, tx_valid, tx_data, rsp_ok, timeout_err, busy});
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: busy=%b tx_valid=%b required 0 0", busy, tx_valid);
    end
    start_xfer();
    collect(24, 0, 0);
    checks++;
    if (got.size() != 24) begin errors++; $display("FAIL rst_restart_count: got %0d required 24", got.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL rst_restart_byte%0d: got %h required %h", i, got[i], exp[i]); end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_idle: busy stuck required 0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_zero_len();
    test_timeout();
    test_rsp_coincident();
    test_ack_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
